// File: rtl/control_pipeline.sv
// Control path of a 5-stage in-order pipeline: E/M/W control registers,
// load-use stall, branch flush and operand forwarding select.
module control_pipeline (
    input  logic       clk,
    input  logic       rst,
    input  logic       RegWriteD,
    input  logic       ALUSrcD,
    input  logic       MemWriteD,
    input  logic       ResultSrcD,
    input  logic       BranchD,
    input  logic [2:0] ALUControlD,
    input  logic [4:0] RdD,
    input  logic [4:0] Rs1D,
    input  logic [4:0] Rs2D,
    input  logic       ZeroE,
    output logic       ALUSrcE,
    output logic [2:0] ALUControlE,
    output logic       PCSrcE,
    output logic       MemWriteM,
    output logic       RegWriteW,
    output logic       ResultSrcW,
    output logic [4:0] RdW,
    output logic [1:0] ForwardAE,
    output logic [1:0] ForwardBE,
    output logic       StallF,
    output logic       StallD,
    output logic       FlushD
);

    localparam int unsigned REG_W = 5;
    localparam int unsigned ALU_W = 3;
    localparam int unsigned FWD_W = 2;

    localparam logic [FWD_W-1:0] FWD_RF = FWD_W'(0);
    localparam logic [FWD_W-1:0] FWD_WB = FWD_W'(1);
    localparam logic [FWD_W-1:0] FWD_MEM = FWD_W'(2);

    typedef struct packed {
        logic             regwrite;
        logic             alusrc;
        logic             memwrite;
        logic             resultsrc;
        logic             branch;
        logic [ALU_W-1:0] alucontrol;
        logic [REG_W-1:0] rd;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
    } e_stage_t;

    typedef struct packed {
        logic             regwrite;
        logic             memwrite;
        logic             resultsrc;
        logic [REG_W-1:0] rd;
    } m_stage_t;

    typedef struct packed {
        logic             regwrite;
        logic             resultsrc;
        logic [REG_W-1:0] rd;
    } w_stage_t;

    e_stage_t e_q;
    m_stage_t m_q;
    w_stage_t w_q;
    e_stage_t e_next;

    logic load_use;
    logic pcsrc;
    logic bubble_e;
    logic [FWD_W-1:0] fwd_a;
    logic [FWD_W-1:0] fwd_b;

    // Hazard detection; a taken branch overrides a load-use stall.
    always_comb begin
        load_use = 1'b0;
        pcsrc    = 1'b0;
        bubble_e = 1'b0;
        load_use = e_q.resultsrc && e_q.regwrite && (e_q.rd != '0)
                   && ((e_q.rd == Rs1D) || (e_q.rd == Rs2D));
        pcsrc    = e_q.branch && ZeroE;
        bubble_e = load_use || pcsrc;
    end

    // Forward select; M is newer than W so it is checked first, x0 never forwards.
    always_comb begin
        fwd_a = FWD_RF;
        fwd_b = FWD_RF;
        if (m_q.regwrite && (m_q.rd != '0) && (m_q.rd == e_q.rs1)) begin
            fwd_a = FWD_MEM;
        end else if (w_q.regwrite && (w_q.rd != '0) && (w_q.rd == e_q.rs1)) begin
            fwd_a = FWD_WB;
        end
        if (m_q.regwrite && (m_q.rd != '0) && (m_q.rd == e_q.rs2)) begin
            fwd_b = FWD_MEM;
        end else if (w_q.regwrite && (w_q.rd != '0) && (w_q.rd == e_q.rs2)) begin
            fwd_b = FWD_WB;
        end
    end

    always_comb begin
        e_next            = '0;
        e_next.regwrite   = RegWriteD;
        e_next.alusrc     = ALUSrcD;
        e_next.memwrite   = MemWriteD;
        e_next.resultsrc  = ResultSrcD;
        e_next.branch     = BranchD;
        e_next.alucontrol = ALUControlD;
        e_next.rd         = RdD;
        e_next.rs1        = Rs1D;
        e_next.rs2        = Rs2D;
    end

    // Stage registers; reset loads bubbles everywhere, hazards bubble only E.
    always_ff @(posedge clk) begin
        if (rst) begin
            e_q <= '0;
            m_q <= '0;
            w_q <= '0;
        end else begin
            e_q <= bubble_e ? e_stage_t'('0) : e_next;
            m_q.regwrite  <= e_q.regwrite;
            m_q.memwrite  <= e_q.memwrite;
            m_q.resultsrc <= e_q.resultsrc;
            m_q.rd        <= e_q.rd;
            w_q.regwrite  <= m_q.regwrite;
            w_q.resultsrc <= m_q.resultsrc;
            w_q.rd        <= m_q.rd;
        end
    end

    assign ALUSrcE     = e_q.alusrc;
    assign ALUControlE = e_q.alucontrol;
    assign MemWriteM   = m_q.memwrite;
    assign RegWriteW   = w_q.regwrite;
    assign ResultSrcW  = w_q.resultsrc;
    assign RdW         = w_q.rd;
    assign PCSrcE      = pcsrc;
    assign StallF      = load_use && !pcsrc;
    assign StallD      = load_use && !pcsrc;
    assign FlushD      = pcsrc;
    assign ForwardAE   = fwd_a;
    assign ForwardBE   = fwd_b;

endmodule
